// File: rtl/alu_operand_issuer_pkg.sv
// Shared opcodes, action-word field positions and FSM encoding
// for the per-lane ALU operand issuer.
package alu_operand_issuer_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;

    localparam int OPC_LSB = 21;
    localparam int OPC_W   = 4;
    localparam int DST_LSB = 18;
    localparam int SRC_LSB = 15;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 15;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/alu_operand_issuer_operand_select.sv
// Combinational container mux for both ALU operands.
// Ports: phv in, idx_1/idx_2 in, cont_1/cont_2 out (0 when idx out of range).
module operand_select
    import alu_operand_issuer_pkg::*;
#(
    parameter int DATA_WIDTH = 48,
    parameter int NUM_CONT   = 8,
    parameter int CIDX_W     = 3
) (
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv,
    input  logic [CIDX_W-1:0]              idx_1,
    input  logic [CIDX_W-1:0]              idx_2,
    output logic [DATA_WIDTH-1:0]          cont_1,
    output logic [DATA_WIDTH-1:0]          cont_2
);

    // Indices with no matching container fall through to 0.
    always_comb begin
        cont_1 = '0;
        cont_2 = '0;
        for (int k = 0; k < NUM_CONT; k++) begin
            if (int'(idx_1) == k) begin
                cont_1 = phv[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (int'(idx_2) == k) begin
                cont_2 = phv[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/alu_operand_issuer.sv
// Single-lane RMT action ALU front/back end: decode, issue, write back.
// Ports: phv_in/action_word in (valid/ready), alu_* issue/result, phv_out (valid/ready), timeout_err.
module alu_operand_issuer
    import alu_operand_issuer_pkg::*;
#(
    parameter int STAGE      = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48,
    parameter int NUM_CONT   = 8,
    parameter int CIDX_W     = 3,
    parameter int MAX_WAIT   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
    input  logic [ACTION_LEN-1:0]          action_word,
    input  logic                           phv_in_valid,
    output logic                           phv_in_ready,
    output logic [ACTION_LEN-1:0]          alu_action,
    output logic                           alu_action_valid,
    output logic [DATA_WIDTH-1:0]          alu_operand_1,
    output logic [DATA_WIDTH-1:0]          alu_operand_2,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    input  logic                           alu_result_valid,
    output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
    output logic                           phv_out_valid,
    input  logic                           phv_out_ready,
    output logic                           timeout_err
);

    localparam int PHV_W = NUM_CONT * DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_t state_q;
    state_t state_d;

    logic [PHV_W-1:0]      phv_q;
    logic [ACTION_LEN-1:0] act_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  tmo_q;

    logic                  accept;
    logic                  wr_en;
    logic                  tmo;

    logic [OPC_W-1:0]      opc_in;
    logic [CIDX_W-1:0]     dst_in;
    logic [CIDX_W-1:0]     src_in;
    logic [IMM_W-1:0]      imm_in;
    logic [CIDX_W-1:0]     dst_q;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] cont_1;
    logic [DATA_WIDTH-1:0] cont_2;
    logic [DATA_WIDTH-1:0] op2_sel;

    assign opc_in  = action_word[OPC_LSB +: OPC_W];
    assign dst_in  = action_word[DST_LSB +: CIDX_W];
    assign src_in  = action_word[SRC_LSB +: CIDX_W];
    assign imm_in  = action_word[IMM_LSB +: IMM_W];
    assign imm_ext = {{(DATA_WIDTH-IMM_W){1'b0}}, imm_in};
    assign dst_q   = act_q[DST_LSB +: CIDX_W];
    assign cnt_inc = cnt_q + 1'b1;

    // STAGE only labels the lane; the mux exists for every stage.
    if (STAGE >= 0) begin : g_sel
        operand_select #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_CONT   (NUM_CONT),
            .CIDX_W     (CIDX_W)
        ) u_sel (
            .phv    (phv_in),
            .idx_1  (dst_in),
            .idx_2  (src_in),
            .cont_1 (cont_1),
            .cont_2 (cont_2)
        );
    end

    always_comb begin
        op2_sel = '0;
        unique case (1'b1)
            (opc_in == OP_ADD) || (opc_in == OP_SUB):
                op2_sel = cont_2;
            (opc_in == OP_ADDI) || (opc_in == OP_SUBI):
                op2_sel = imm_ext;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A result in the final wait cycle beats the timeout.
    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        wr_en            = 1'b0;
        tmo              = 1'b0;
        phv_in_ready     = 1'b0;
        alu_action_valid = 1'b0;
        phv_out_valid    = 1'b0;
        unique case (state_q)
            IDLE: begin
                phv_in_ready = 1'b1;
                if (phv_in_valid) begin
                    accept  = 1'b1;
                    state_d = (opc_in == OP_NOP) ? OUT : ISSUE;
                end
            end
            ISSUE: begin
                alu_action_valid = 1'b1;
                state_d          = WAIT;
            end
            WAIT: begin
                if (alu_result_valid) begin
                    wr_en   = 1'b1;
                    state_d = OUT;
                end else if (cnt_inc == CNT_W'(MAX_WAIT)) begin
                    tmo     = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                phv_out_valid = 1'b1;
                if (phv_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_q <= '0;
            act_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo;
            if (accept) begin
                phv_q <= phv_in;
                act_q <= action_word;
                op1_q <= cont_1;
                op2_q <= op2_sel;
            end
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_inc;
            end
            // Out-of-range destination matches no slot: write dropped.
            if (wr_en) begin
                for (int k = 0; k < NUM_CONT; k++) begin
                    if (int'(dst_q) == k) begin
                        phv_q[k*DATA_WIDTH +: DATA_WIDTH] <= alu_result;
                    end
                end
            end
        end
    end

    assign alu_action    = act_q;
    assign alu_operand_1 = op1_q;
    assign alu_operand_2 = op2_q;
    assign phv_out       = phv_q;
    assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_alu_operand_issuer.sv
// Randomized and directed bench for alu_operand_issuer with an ALU model.
// Expected PHVs come from a container-level reference model.
module tb_alu_operand_issuer;

    localparam int DW = 48;
    localparam int NC = 8;
    localparam int PW = NC * DW;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] phv_in;
    logic [24:0]   action_word;
    logic          phv_in_valid;
    logic          phv_in_ready;
    logic [24:0]   alu_action;
    logic          alu_action_valid;
    logic [DW-1:0] alu_operand_1;
    logic [DW-1:0] alu_operand_2;
    logic [DW-1:0] alu_result = '0;
    logic          alu_result_valid = 1'b0;
    logic [PW-1:0] phv_out;
    logic          phv_out_valid;
    logic          phv_out_ready;
    logic          timeout_err;

    int n_cmp = 0;
    int n_mis = 0;
    int alu_delay = 3;

    alu_operand_issuer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .phv_in           (phv_in),
        .action_word      (action_word),
        .phv_in_valid     (phv_in_valid),
        .phv_in_ready     (phv_in_ready),
        .alu_action       (alu_action),
        .alu_action_valid (alu_action_valid),
        .alu_operand_1    (alu_operand_1),
        .alu_operand_2    (alu_operand_2),
        .alu_result       (alu_result),
        .alu_result_valid (alu_result_valid),
        .phv_out          (phv_out),
        .phv_out_valid    (phv_out_valid),
        .phv_out_ready    (phv_out_ready),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [3:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            4'd1, 4'd9:  return a + b;
            4'd2, 4'd10: return a - b;
            default:     return a ^ b;
        endcase
    endfunction

    function automatic logic [DW-1:0] cont(input logic [PW-1:0] p, input int i);
        return (i < NC) ? p[i*DW +: DW] : '0;
    endfunction

    function automatic logic [PW-1:0] rnd_phv();
        logic [PW-1:0] p;
        for (int k = 0; k < NC; k++) p[k*DW +: DW] = {16'($urandom), $urandom};
        return p;
    endfunction

    // ALU model: answers alu_delay cycles after the issue cycle.
    int          alu_cd = 0;
    logic [3:0]  alu_op;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    always @(negedge clk) begin
        alu_result_valid = 1'b0;
        alu_result = {16'($urandom), $urandom};
        if (alu_cd > 0) begin
            alu_cd--;
            if (alu_cd == 0) begin
                alu_result_valid = 1'b1;
                alu_result = alu_f(alu_op, alu_a, alu_b);
            end
        end
        if (alu_action_valid === 1'b1) begin
            alu_cd = alu_delay;
            alu_op = alu_action[24:21];
            alu_a  = alu_operand_1;
            alu_b  = alu_operand_2;
        end
    end

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input string tag, input logic [PW-1:0] p, input logic [24:0] a,
                       input int dly, input int bp, output logic [PW-1:0] got);
        logic [3:0]    opc;
        int            d;
        int            s;
        logic [DW-1:0] o1;
        logic [DW-1:0] o2;
        logic [PW-1:0] ex;
        bit            iss;
        bit            to;
        bit            seen;
        int            lat;
        int            c;
        opc = a[24:21];
        d   = int'(a[20:18]);
        s   = int'(a[17:15]);
        iss = (opc != 4'd0);
        o1  = cont(p, d);
        if (opc == 4'd1 || opc == 4'd2)       o2 = cont(p, s);
        else if (opc == 4'd9 || opc == 4'd10) o2 = {33'd0, a[14:0]};
        else                                  o2 = '0;
        to  = iss && (dly > MW);
        lat = !iss ? 1 : (to ? MW + 2 : dly + 2);
        ex  = p;
        if (iss && !to && d < NC) ex[d*DW +: DW] = alu_f(opc, o1, o2);
        alu_delay     = dly;
        phv_out_ready = (bp == 0);
        chk({tag, "/in_ready_idle"}, phv_in_ready, 1);
        phv_in       = p;
        action_word  = a;
        phv_in_valid = 1'b1;
        @(negedge clk);
        phv_in_valid = 1'b0;
        phv_in       = rnd_phv();
        c    = 1;
        seen = 0;
        while (!seen && c <= 40) begin
            chk({tag, "/issue_valid"}, alu_action_valid, (iss && c == 1));
            if (iss && c == 1) begin
                chk({tag, "/action"}, alu_action, a);
                chk({tag, "/op1"}, alu_operand_1, o1);
                chk({tag, "/op2"}, alu_operand_2, o2);
            end
            chk({tag, "/in_ready_busy"}, phv_in_ready, 0);
            if (phv_out_valid === 1'b1) begin
                seen = 1;
                chk({tag, "/latency"}, c, lat);
                chk({tag, "/phv_out"}, phv_out, ex);
                chk({tag, "/timeout_err"}, timeout_err, to);
            end else begin
                chk({tag, "/no_early_tmo"}, timeout_err, 0);
                @(negedge clk);
                c++;
            end
        end
        if (!seen) chk({tag, "/out_valid_bound"}, 0, 1);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({tag, "/bp_valid"}, phv_out_valid, 1);
            chk({tag, "/bp_phv"}, phv_out, ex);
            chk({tag, "/bp_in_ready"}, phv_in_ready, 0);
            chk({tag, "/bp_tmo"}, timeout_err, 0);
        end
        got = phv_out;
        phv_out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "/valid_drop"}, phv_out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "/post_valid"}, phv_out_valid, 0);
            chk({tag, "/post_phv"}, phv_out, ex);
            chk({tag, "/post_tmo"}, timeout_err, 0);
            chk({tag, "/post_issue"}, alu_action_valid, 0);
            chk({tag, "/post_in_ready"}, phv_in_ready, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] p;
        logic [PW-1:0] got;
        logic [3:0]    opc;
        int            k;
        rst_n         = 1'b0;
        phv_in        = '0;
        action_word   = '0;
        phv_in_valid  = 1'b0;
        phv_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst/in_ready", phv_in_ready, 1);
        chk("rst/out_valid", phv_out_valid, 0);
        chk("rst/phv_out", phv_out, 0);
        chk("rst/issue", alu_action_valid, 0);
        chk("rst/action", alu_action, 0);
        chk("rst/op1", alu_operand_1, 0);
        chk("rst/op2", alu_operand_2, 0);
        chk("rst/tmo", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        p = rnd_phv();
        p[2*DW +: DW] = 48'd100;
        p[5*DW +: DW] = 48'd7;
        txn("add", p, {4'b0001, 3'd2, 3'd5, 15'd0}, 3, 0, got);
        chk("add/c2_const", got[2*DW +: DW], 48'd107);

        p = rnd_phv();
        p[0 +: DW] = 48'd5;
        txn("addi", p, {4'b1001, 3'd0, 3'd6, 15'h1234}, 3, 0, got);
        chk("addi/c0_const", got[0 +: DW], 48'h1239);

        txn("nop", rnd_phv(), {4'b0000, 3'd3, 3'd1, 15'h7abc}, 3, 0, got);
        txn("other", rnd_phv(), {4'b0101, 3'd4, 3'd1, 15'h0042}, 2, 0, got);
        txn("timeout", rnd_phv(), {4'b0010, 3'd1, 3'd7, 15'd0}, MW + 3, 0, got);
        txn("last_wait", rnd_phv(), {4'b1010, 3'd7, 3'd0, 15'h00ff}, MW, 0, got);
        txn("backpressure", rnd_phv(), {4'b0001, 3'd6, 3'd3, 15'd0}, 3, 10, got);
        txn("after_bp", rnd_phv(), {4'b0010, 3'd3, 3'd6, 15'd0}, 3, 0, got);

        // Reset while waiting on the ALU; its later result must be ignored.
        alu_delay    = 3;
        phv_in       = rnd_phv();
        action_word  = {4'b0001, 3'd1, 3'd2, 15'd0};
        phv_in_valid = 1'b1;
        @(negedge clk);
        phv_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstwait/in_ready", phv_in_ready, 1);
        chk("rstwait/out_valid", phv_out_valid, 0);
        chk("rstwait/phv_out", phv_out, 0);
        chk("rstwait/action", alu_action, 0);
        chk("rstwait/op1", alu_operand_1, 0);
        chk("rstwait/op2", alu_operand_2, 0);
        chk("rstwait/tmo", timeout_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstwait/post_valid", phv_out_valid, 0);
            chk("rstwait/post_phv", phv_out, 0);
            chk("rstwait/post_in_ready", phv_in_ready, 1);
            chk("rstwait/post_issue", alu_action_valid, 0);
            chk("rstwait/post_tmo", timeout_err, 0);
        end
        txn("recover", rnd_phv(), {4'b1001, 3'd5, 3'd0, 15'h0fff}, 3, 0, got);

        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: opc = 4'd0;
                1: opc = 4'd1;
                2: opc = 4'd2;
                3: opc = 4'd9;
                4: opc = 4'd10;
                default: opc = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(3, 8))
                                                          : 4'($urandom_range(11, 15));
            endcase
            txn("rand", rnd_phv(),
                {opc, 3'($urandom), 3'($urandom), 15'($urandom)},
                ($urandom_range(0, 4) == 0) ? $urandom_range(MW + 1, MW + 4)
                                            : $urandom_range(1, MW),
                $urandom_range(0, 3), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_operand_issuer.md
Name: alu_operand_issuer

Overview:
- Single-lane front/back end for one RMT action ALU.
- Accepts a PHV plus that lane's 25-bit action word and decodes the opcode and operand selects.
- Drives action/operands into the ALU, then captures the ALU's result and writes it back into the destination container.
- Emits the updated PHV downstream. Sits between the action-VLIW fetch and the PHV output of each stage.

Parameters:
- STAGE, 0, stage index (informational only).
- ACTION_LEN, 25, width of the per-lane action word.
- DATA_WIDTH, 48, container width (ALU data width).
- NUM_CONT, 8, number of containers in the PHV.
- CIDX_W, 3, width of a container index field.
- MAX_WAIT, 8, maximum cycles spent waiting for the ALU result before timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- phv_in  in  NUM_CONT*DATA_WIDTH  input PHV; container k = phv_in[k*DATA_WIDTH +: DATA_WIDTH]
- action_word  in  ACTION_LEN  lane action, sampled together with phv_in
- phv_in_valid  in  1  input PHV valid
- phv_in_ready  out  1  block can accept a PHV
- alu_action  out  ACTION_LEN  action forwarded to the ALU
- alu_action_valid  out  1  one-cycle issue strobe
- alu_operand_1  out  DATA_WIDTH  first ALU operand
- alu_operand_2  out  DATA_WIDTH  second ALU operand
- alu_result  in  DATA_WIDTH  ALU container_out
- alu_result_valid  in  1  ALU container_out_valid
- phv_out  out  NUM_CONT*DATA_WIDTH  updated PHV
- phv_out_valid  out  1  output PHV valid
- phv_out_ready  in  1  downstream ready
- timeout_err  out  1  one-cycle pulse when the ALU result does not arrive in time

Behaviour:
- Action word decode:
  - [24:21] opcode.
  - [20:18] op1/destination index.
  - [17:15] op2 index.
  - [14:0] immediate, zero-extended to DATA_WIDTH.
- Operand selection:
  - 0001 add, 0010 sub: op1 = cont[op1 idx], op2 = cont[op2 idx].
  - 1001 addi, 1010 subi: op1 = cont[op1 idx], op2 = immediate.
  - 0000: nop, no ALU issue.
  - Any other opcode: op1 = cont[op1 idx], op2 = 0, issued.
- Index ≥ NUM_CONT: that operand reads as 0 and the writeback is suppressed.
- Reset values: all outputs 0 except phv_in_ready = 1. State IDLE, wait counter 0.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - phv_in_ready = 1.
  - On phv_in_valid, register phv_in and action_word.
  - Go to OUT if the opcode is nop, otherwise to ISSUE.
- ISSUE:
  - alu_action_valid = 1 for exactly one cycle.
  - alu_action and both operands are registered and stable that cycle.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On alu_result_valid: write alu_result into the buffered PHV at the op1 index, then go to OUT.
  - If the counter reaches MAX_WAIT without a result: pulse timeout_err, pass the PHV unmodified, go to OUT.
  - A result and the timeout in the same cycle: the result wins, no error.
- Nominal ALU latency is 3 cycles: alu_action_valid at cycle t gives alu_result_valid at t+3. Accept-to-phv_out_valid is therefore 5 cycles.
- OUT:
  - phv_out_valid = 1; phv_out held stable until phv_out_ready.
  - On ready, drop valid and return to IDLE.
  - phv_in_ready = 0 in every non-IDLE state; there is no bypass and no overlap.
- alu_result_valid outside WAIT is ignored, including stale results after a timeout.
- alu_action_valid never asserts outside ISSUE.
- Reset asserted mid-operation: in-flight PHV dropped, outputs return to reset values immediately (async). Results arriving after reset are ignored.
- Arithmetic is done in the ALU; this block performs no arithmetic and only does width-exact slicing and merging.

Decomposition:
- Shared package:
  - Opcode localparams (OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI).
  - Action field bit positions.
  - FSM state encoding.
- Sub-module: operand_select (combinational container mux for op1/op2 including the out-of-range-to-0 rule). It is reused by future lanes.

Test Plan:
- Add: containers {c2 = 100, c5 = 7}, opcode 0001, op1 = 2, op2 = 5 -> in ISSUE, alu_operand_1 = 100, alu_operand_2 = 7, valid for one cycle. Model ALU returns 107 at +3 -> phv_out has c2 = 107, others unchanged, 5-cycle latency.
- Immediate: opcode 1001, op1 = 0, imm = 0x1234, c0 = 5 -> operands 5 and 0x1234. Result 0x1239 written into c0.
- Nop: opcode 0000 -> no alu_action_valid, phv_out == phv_in, valid 1 cycle after accept.
- Timeout: ALU never responds, MAX_WAIT = 8 -> timeout_err pulses once, phv_out unmodified. A late result 2 cycles later is ignored.
- Backpressure: phv_out_ready low 10 cycles -> phv_out_valid/phv_out stable, phv_in_ready = 0 throughout. A second PHV is accepted only after the handshake.
- Reset in WAIT: assert rst_n low 2 cycles -> all outputs 0, phv_in_ready = 1. The following result pulse does not alter anything.
